// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main control FSM: sequences each instruction and drives datapath enables/muxes.
// Optional retired-instruction counter (InstrCount port) is built when INSTR_COUNT_EN is defined.
module main_control_fsm #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Op,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALU_Op,
   output logic [1:0] ImmSrc,
   output logic [3:0] State
`ifdef INSTR_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0] InstrCount
`endif
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_e;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_ITYP = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   if (CNT_WIDTH < 1) begin : g_bad_width
      $error("CNT_WIDTH must be at least 1");
   end

   state_e state_q, state_d;
   state_e dec_state;

   logic pc_update, branch;
   logic mem_write_st, ir_write_st, reg_write_st;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYP:      state_d = S_EXECUTER;
               OP_ITYP:      state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // During reset the mux controls already show FETCH; write enables are masked below.
   assign dec_state = rst ? S_FETCH : state_q;

   always_comb begin
      pc_update    = 1'b0;
      branch       = 1'b0;
      AdrSrc       = 1'b0;
      mem_write_st = 1'b0;
      ir_write_st  = 1'b0;
      reg_write_st = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALU_Op       = 2'b00;
      case (dec_state)
         S_FETCH: begin
            ir_write_st = 1'b1;
            ALUSrcB     = 2'b10;
            ResultSrc   = 2'b10;
            pc_update   = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc    = 2'b01;
            reg_write_st = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc       = 1'b1;
            mem_write_st = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            ALU_Op  = 2'b10;
         end
         S_ALUWB: reg_write_st = 1'b1;
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALU_Op  = 2'b11;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALU_Op  = 2'b01;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   assign PCWrite  = (pc_update | (branch & Zero)) & ~rst;
   assign MemWrite = mem_write_st & ~rst;
   assign IRWrite  = ir_write_st & ~rst;
   assign RegWrite = reg_write_st & ~rst;

   always_comb begin
      case (Op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   assign State = state_q;

`ifdef INSTR_COUNT_EN
   // Only completing states count; the unsupported-opcode DECODE->FETCH skip does not.
   logic [CNT_WIDTH-1:0] instr_count_q;
   logic                 retire;

   assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                   (state_q == S_ALUWB) || (state_q == S_BEQ);

   always_ff @(posedge clk) begin
      if (rst)         instr_count_q <= '0;
      else if (retire) instr_count_q <= instr_count_q + CNT_WIDTH'(1);
   end

   assign InstrCount = instr_count_q;
`else
   // Counter omitted in this build.
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: reset/abort sequences plus a table of per-cycle vectors.
module tb_main_control_fsm;

   localparam int unsigned CNT_WIDTH = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] Op;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALU_Op, ImmSrc;
   logic [3:0] State;
`ifdef INSTR_COUNT_EN
   logic [CNT_WIDTH-1:0] InstrCount;
`endif

   main_control_fsm #(.CNT_WIDTH(CNT_WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .Op        (Op),
      .Zero      (Zero),
      .PCWrite   (PCWrite),
      .AdrSrc    (AdrSrc),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALU_Op    (ALU_Op),
      .ImmSrc    (ImmSrc),
      .State     (State)
`ifdef INSTR_COUNT_EN
      ,
      .InstrCount(InstrCount)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   // Expected Moore outputs per state (PCWrite is carried in each vector).
   typedef struct {
      logic       adr, mw, irw, rw;
      logic [1:0] rs, sa, sb, aop;
   } ctrl_t;

   typedef struct {
      logic [6:0]  op;
      logic        zero;
      logic [3:0]  st;
      logic        pcw;
      logic [1:0]  imm;
      logic [31:0] cnt;
   } vec_t;

   ctrl_t exp_ctrl [16];
   vec_t  vecs[$];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [6:0] op, input logic zero, input logic [3:0] st,
                      input logic pcw, input logic [1:0] imm, input logic [31:0] cnt);
      vec_t v;
      v.op = op; v.zero = zero; v.st = st; v.pcw = pcw; v.imm = imm; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic check_cnt(input string name, input logic [31:0] exp);
`ifdef INSTR_COUNT_EN
      check(name, 32'(InstrCount), exp);
`else
      if (exp === 32'hx) $display("unexpected counter expectation %s", name);
`endif
   endtask

   initial begin
      //                 adr   mw    irw   rw    rs     sa     sb     aop
      exp_ctrl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00}; // FETCH
      exp_ctrl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00}; // DECODE
      exp_ctrl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00}; // MEMADR
      exp_ctrl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00}; // MEMREAD
      exp_ctrl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00}; // MEMWB
      exp_ctrl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00}; // MEMWRITE
      exp_ctrl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10}; // EXECUTER
      exp_ctrl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00}; // ALUWB
      exp_ctrl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b11}; // EXECUTEI
      exp_ctrl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00}; // JAL
      exp_ctrl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01}; // BEQ
      for (int s = 11; s < 16; s++) exp_ctrl[s] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};

      // lw: 0,1,2,3,4
      add(LW, 1'b0, 4'd0, 1'b1, 2'b00, 0); add(LW, 1'b0, 4'd1, 1'b0, 2'b00, 0);
      add(LW, 1'b0, 4'd2, 1'b0, 2'b00, 0); add(LW, 1'b0, 4'd3, 1'b0, 2'b00, 0);
      add(LW, 1'b0, 4'd4, 1'b0, 2'b00, 0);
      // sw: 0,1,2,5
      add(SW, 1'b0, 4'd0, 1'b1, 2'b01, 1); add(SW, 1'b0, 4'd1, 1'b0, 2'b01, 1);
      add(SW, 1'b0, 4'd2, 1'b0, 2'b01, 1); add(SW, 1'b0, 4'd5, 1'b0, 2'b01, 1);
      // beq taken, then not taken: 0,1,10
      add(BQ, 1'b1, 4'd0, 1'b1, 2'b10, 2); add(BQ, 1'b1, 4'd1, 1'b0, 2'b10, 2);
      add(BQ, 1'b1, 4'd10, 1'b1, 2'b10, 2);
      add(BQ, 1'b0, 4'd0, 1'b1, 2'b10, 3); add(BQ, 1'b0, 4'd1, 1'b0, 2'b10, 3);
      add(BQ, 1'b0, 4'd10, 1'b0, 2'b10, 3);
      // R-type: 0,1,6,7 ; addi: 0,1,8,7
      add(RT, 1'b0, 4'd0, 1'b1, 2'b00, 4); add(RT, 1'b0, 4'd1, 1'b0, 2'b00, 4);
      add(RT, 1'b1, 4'd6, 1'b0, 2'b00, 4); add(RT, 1'b0, 4'd7, 1'b0, 2'b00, 4);
      add(IT, 1'b0, 4'd0, 1'b1, 2'b00, 5); add(IT, 1'b0, 4'd1, 1'b0, 2'b00, 5);
      add(IT, 1'b0, 4'd8, 1'b0, 2'b00, 5); add(IT, 1'b0, 4'd7, 1'b0, 2'b00, 5);
      // jal: 0,1,9,7 ; unsupported: 0,1 ; then FETCH with count unchanged
      add(JL, 1'b0, 4'd0, 1'b1, 2'b11, 6); add(JL, 1'b0, 4'd1, 1'b0, 2'b11, 6);
      add(JL, 1'b0, 4'd9, 1'b1, 2'b11, 6); add(JL, 1'b0, 4'd7, 1'b0, 2'b11, 6);
      add(BAD, 1'b0, 4'd0, 1'b1, 2'b00, 7); add(BAD, 1'b0, 4'd1, 1'b0, 2'b00, 7);
      add(LW, 1'b0, 4'd0, 1'b1, 2'b00, 7);

      // Power-up reset for two edges.
      rst = 1'b1; Op = RT; Zero = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("por state", 32'(State), 0);
      check("por irwrite", 32'(IRWrite), 1);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rtype reach executer", 32'(State), 6);
      check("executer aluop", 32'(ALU_Op), 2);

      // Abort from EXECUTER: two reset cycles.
      rst = 1'b1;
      #1;
      check("rst exec state held", 32'(State), 6);
      check("rst exec pcwrite", 32'(PCWrite), 0);
      check("rst exec regwrite", 32'(RegWrite), 0);
      check("rst exec memwrite", 32'(MemWrite), 0);
      check("rst exec irwrite", 32'(IRWrite), 0);
      check("rst exec alusrcb fetch", 32'(ALUSrcB), 2);
      check("rst exec aluop fetch", 32'(ALU_Op), 0);
      @(negedge clk);
      #1;
      check("rst edge state", 32'(State), 0);
      check("rst fetch irwrite", 32'(IRWrite), 0);
      check("rst fetch pcwrite", 32'(PCWrite), 0);
      @(negedge clk);
      rst = 1'b0; Op = LW;
      #1;
      check("post rst state", 32'(State), 0);
      check("post rst pcwrite", 32'(PCWrite), 1);
      repeat (4) @(negedge clk);
      #1;
      check("lw reach memwb", 32'(State), 4);
      check("memwb regwrite", 32'(RegWrite), 1);

      // Abort a writeback: RegWrite must drop and no instruction retires.
      rst = 1'b1;
      #1;
      check("rst memwb regwrite", 32'(RegWrite), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort state", 32'(State), 0);
      check_cnt("abort count", 0);

      foreach (vecs[i]) begin
         ctrl_t c;
         c = exp_ctrl[vecs[i].st];
         Op = vecs[i].op; Zero = vecs[i].zero;
         #1;
         check($sformatf("v%0d state", i),     32'(State),     32'(vecs[i].st));
         check($sformatf("v%0d pcwrite", i),   32'(PCWrite),   32'(vecs[i].pcw));
         check($sformatf("v%0d adrsrc", i),    32'(AdrSrc),    32'(c.adr));
         check($sformatf("v%0d memwrite", i),  32'(MemWrite),  32'(c.mw));
         check($sformatf("v%0d irwrite", i),   32'(IRWrite),   32'(c.irw));
         check($sformatf("v%0d regwrite", i),  32'(RegWrite),  32'(c.rw));
         check($sformatf("v%0d resultsrc", i), 32'(ResultSrc), 32'(c.rs));
         check($sformatf("v%0d alusrca", i),   32'(ALUSrcA),   32'(c.sa));
         check($sformatf("v%0d alusrcb", i),   32'(ALUSrcB),   32'(c.sb));
         check($sformatf("v%0d aluop", i),     32'(ALU_Op),    32'(c.aop));
         check($sformatf("v%0d immsrc", i),    32'(ImmSrc),    32'(vecs[i].imm));
         check_cnt($sformatf("v%0d count", i), vecs[i].cnt);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
